checkpoint_monitor: RTL and testbench

Synthesizable, parametrised successor to the CPU bench's checkpoint table. It holds NUM_TEST (instruction-count, expected-output) pairs, loaded through a config port. While running, it compares the CPU's `num_inst`/`output_port` against every entry each cycle and stops on halt, first failure or cycle timeout. It then serially tallies pass, fail and no-result counts. It sits beside `cpu` on the FPGA/emulation top, so test verdicts no longer depend on a simulation-only bench.

---
 rtl/checkpoint_monitor.sv | 177 +++++++++++++++++
 tb/tb_checkpoint_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: checks CPU num_inst/output_port against a loadable checkpoint table, then tallies results.
// Define CKMON_TIMEOUT_EN to stop the run after MAX_CYCLES RUN cycles.
module checkpoint_monitor #(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_TEST     = 56,
    parameter int IDX_W        = 6,
    parameter int CYCLE_W      = 16,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WORD_SIZE-1:0] cfg_inst,
    input  logic [WORD_SIZE-1:0] cfg_ans,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    output logic                 busy,
    output logic                 done,
    output logic                 all_pass,
    output logic [IDX_W:0]       pass_count,
    output logic [IDX_W:0]       fail_count,
    output logic [IDX_W:0]       noresult_count,
    output logic                 first_fail_valid,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [WORD_SIZE-1:0] first_fail_value,
    output logic [CYCLE_W-1:0]   num_clock,
    output logic                 halted_seen,
    output logic                 timed_out
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_SCAN = 2'd2, S_DONE = 2'd3;
    localparam logic [1:0] ST_UNSEEN = 2'd0, ST_PASS = 2'd1, ST_FAIL = 2'd2;
`ifdef CKMON_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] inst_q [NUM_TEST];
    logic [WORD_SIZE-1:0] inst_d [NUM_TEST];
    logic [WORD_SIZE-1:0] ans_q [NUM_TEST];
    logic [WORD_SIZE-1:0] ans_d [NUM_TEST];
    logic [1:0]           status_q [NUM_TEST];
    logic [1:0]           status_d [NUM_TEST];
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic [IDX_W:0]       pass_q, pass_d, fail_q, fail_d, nores_q, nores_d;
    logic                 ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
    logic [WORD_SIZE-1:0] ff_value_q, ff_value_d;
    logic [CYCLE_W-1:0]   num_clock_q, num_clock_d, num_clock_inc;
    logic                 halted_q, halted_d, timed_out_q, timed_out_d;
    logic                 mismatch, timeout, stop;
    logic [IDX_W-1:0]     mis_idx;
    logic [1:0]           scan_st;

    // Descending loop so the lowest mismatching index is the one left in mis_idx.
    always_comb begin
        inst_d   = inst_q;
        ans_d    = ans_q;
        status_d = status_q;
        mismatch = 1'b0;
        mis_idx  = '0;
        scan_st  = ST_UNSEEN;
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            if (state_q == S_IDLE) begin
                status_d[i] = ST_UNSEEN;
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    inst_d[i] = cfg_inst;
                    ans_d[i]  = cfg_ans;
                end
            end
            if (state_q == S_RUN && num_inst == inst_q[i]) begin
                status_d[i] = (output_port == ans_q[i] && status_q[i] != ST_FAIL) ? ST_PASS : ST_FAIL;
                if (output_port != ans_q[i]) begin
                    mismatch = 1'b1;
                    mis_idx  = IDX_W'(i);
                end
            end
            if (scan_idx_q == IDX_W'(i)) scan_st = status_q[i];
        end
    end

    always_comb begin
        num_clock_inc = &num_clock_q ? num_clock_q : num_clock_q + CYCLE_W'(1);
        timeout       = TIMEOUT_EN && num_clock_inc == CYCLE_W'(MAX_CYCLES);
        stop          = is_halted || timeout || (STOP_ON_FAIL != 0 && mismatch);
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        nores_d       = nores_q;
        ff_valid_d    = ff_valid_q;
        ff_idx_d      = ff_idx_q;
        ff_value_d    = ff_value_q;
        num_clock_d   = num_clock_q;
        halted_d      = halted_q;
        timed_out_d   = timed_out_q;
        case (state_q)
            S_IDLE: state_d = start ? S_RUN : S_IDLE;
            S_RUN: begin
                num_clock_d = num_clock_inc;
                if (mismatch && !ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = mis_idx;
                    ff_value_d = output_port;
                end
                if (stop) begin
                    state_d     = S_SCAN;
                    scan_idx_d  = '0;
                    pass_d      = '0;
                    fail_d      = '0;
                    nores_d     = '0;
                    halted_d    = is_halted;
                    timed_out_d = timeout;
                end
            end
            S_SCAN: begin
                pass_d     = pass_q + {{IDX_W{1'b0}}, scan_st == ST_PASS};
                fail_d     = fail_q + {{IDX_W{1'b0}}, scan_st == ST_FAIL};
                nores_d    = nores_q + {{IDX_W{1'b0}}, scan_st == ST_UNSEEN};
                scan_idx_d = scan_idx_q + IDX_W'(1);
                state_d    = (scan_idx_q == IDX_W'(NUM_TEST - 1)) ? S_DONE : S_SCAN;
            end
            default: ;
        endcase
    end

    // The table deliberately has no reset so it survives a mid-run reset.
    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        ans_q  <= ans_d;
        if (!reset_n) begin
            state_q     <= S_IDLE;
            status_q    <= '{default: ST_UNSEEN};
            scan_idx_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            nores_q     <= '0;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= '0;
            ff_value_q  <= '0;
            num_clock_q <= '0;
            halted_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            scan_idx_q  <= scan_idx_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            nores_q     <= nores_d;
            ff_valid_q  <= ff_valid_d;
            ff_idx_q    <= ff_idx_d;
            ff_value_q  <= ff_value_d;
            num_clock_q <= num_clock_d;
            halted_q    <= halted_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign busy             = state_q == S_RUN || state_q == S_SCAN;
    assign done             = state_q == S_DONE;
    assign all_pass         = done && pass_q == (IDX_W + 1)'(NUM_TEST);
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign noresult_count   = nores_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_value = ff_value_q;
    assign num_clock        = num_clock_q;
    assign halted_seen      = halted_q;
    assign timed_out        = timed_out_q;
endmodule

// File: tb/tb_checkpoint_monitor.sv
// tb_checkpoint_monitor: directed bench; dut stops on first fail, dut_nf (STOP_ON_FAIL=0) runs on.
module tb_checkpoint_monitor;
    localparam int W = 16, N = 4, IW = 3, CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0, cfg_we = 1'b0, start = 1'b0, is_halted = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [W-1:0] cfg_inst = '0, cfg_ans = '0, num_inst = '0, output_port = '0;

    logic a_busy, a_done, a_all_pass, a_ffv, a_hs, a_to;
    logic [IW:0] a_pass, a_fail, a_nores;
    logic [IW-1:0] a_ffi;
    logic [W-1:0] a_ffval;
    logic [CW-1:0] a_nclk;
    logic b_busy, b_done, b_all_pass, b_ffv, b_hs, b_to;
    logic [IW:0] b_pass, b_fail, b_nores;
    logic [IW-1:0] b_ffi;
    logic [W-1:0] b_ffval;
    logic [CW-1:0] b_nclk;

    int checks = 0, errors = 0;

    checkpoint_monitor #(.WORD_SIZE(W), .NUM_TEST(N), .IDX_W(IW), .CYCLE_W(CW), .MAX_CYCLES(20), .STOP_ON_FAIL(1)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_inst(cfg_inst), .cfg_ans(cfg_ans),
        .start(start), .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
        .busy(a_busy), .done(a_done), .all_pass(a_all_pass), .pass_count(a_pass), .fail_count(a_fail),
        .noresult_count(a_nores), .first_fail_valid(a_ffv), .first_fail_idx(a_ffi), .first_fail_value(a_ffval),
        .num_clock(a_nclk), .halted_seen(a_hs), .timed_out(a_to));

    checkpoint_monitor #(.WORD_SIZE(W), .NUM_TEST(N), .IDX_W(IW), .CYCLE_W(CW), .MAX_CYCLES(20), .STOP_ON_FAIL(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_inst(cfg_inst), .cfg_ans(cfg_ans),
        .start(start), .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
        .busy(b_busy), .done(b_done), .all_pass(b_all_pass), .pass_count(b_pass), .fail_count(b_fail),
        .noresult_count(b_nores), .first_fail_valid(b_ffv), .first_fail_idx(b_ffi), .first_fail_value(b_ffval),
        .num_clock(b_nclk), .halted_seen(b_hs), .timed_out(b_to));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [W-1:0] ni, input logic [W-1:0] op);
        num_inst = ni;
        output_port = op;
        tick(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        is_halted = 1'b0;
        num_inst = '0;
        output_port = '0;
        tick(1);
        reset_n = 1'b1;
    endtask

    task automatic run_s1();
        is_halted = 1'b0;
        num_inst = '0;
        output_port = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drive(16'h3, 16'h0);
        drive(16'h5, 16'h0);
        drive(16'hb, 16'h1);
        drive(16'hd, 16'h2);
        is_halted = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({a_busy, a_done, a_all_pass, a_pass, a_fail, a_nores, a_ffv, a_ffi, a_ffval, a_nclk, a_hs, a_to} !== '0) begin errors++; $display("FAIL reset_a got %h exp 0", {a_busy, a_done, a_all_pass, a_pass, a_fail, a_nores, a_ffv, a_ffi, a_ffval, a_nclk, a_hs, a_to}); end
        checks++; if ({b_busy, b_done, b_all_pass, b_pass, b_fail, b_nores, b_ffv, b_ffi, b_ffval, b_nclk, b_hs, b_to} !== '0) begin errors++; $display("FAIL reset_b got %h exp 0", {b_busy, b_done, b_all_pass, b_pass, b_fail, b_nores, b_ffv, b_ffi, b_ffval, b_nclk, b_hs, b_to}); end
    endtask

    task automatic test_load();
        logic [W-1:0] ti [6] = '{16'h3, 16'h5, 16'hb, 16'hd, 16'h3, 16'h5};
        logic [W-1:0] ta [6] = '{16'h0, 16'h0, 16'h1, 16'h2, 16'h9, 16'h9};
        logic [IW-1:0] tx [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 6; i++) begin
            cfg_we = 1'b1;
            cfg_idx = tx[i];
            cfg_inst = ti[i];
            cfg_ans = ta[i];
            tick(1);
        end
        cfg_we = 1'b0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL load_idle got %0b exp 0", a_busy); end
    endtask

    task automatic test_all_pass();
        run_s1();
        checks++; if (a_busy !== 1'b1 || a_hs !== 1'b1) begin errors++; $display("FAIL s1_scan busy=%0b halted=%0b exp 1 1", a_busy, a_hs); end
        tick(3);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL s1_done_early got %0b exp 0", a_done); end
        tick(1);
        checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL s1_done done=%0b busy=%0b exp 1 0", a_done, a_busy); end
        checks++; if (a_pass !== 4 || a_fail !== 0 || a_nores !== 0) begin errors++; $display("FAIL s1_counts got %0d/%0d/%0d exp 4/0/0", a_pass, a_fail, a_nores); end
        checks++; if (a_all_pass !== 1'b1 || a_ffv !== 1'b0 || a_to !== 1'b0) begin errors++; $display("FAIL s1_flags all=%0b ffv=%0b to=%0b exp 1 0 0", a_all_pass, a_ffv, a_to); end
        checks++; if (a_nclk !== 5) begin errors++; $display("FAIL s1_num_clock got %0d exp 5", a_nclk); end
        is_halted = 1'b0;
    endtask

    task automatic test_first_fail();
        do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drive(16'h3, 16'h0);
        drive(16'h5, 16'h0);
        drive(16'hb, 16'h2);
        checks++; if (a_ffv !== 1'b1 || a_ffi !== 2 || a_ffval !== 16'h2) begin errors++; $display("FAIL s2_capture v=%0b idx=%0d val=%h exp 1 2 0002", a_ffv, a_ffi, a_ffval); end
        checks++; if (a_hs !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL s2_stop halted=%0b busy=%0b exp 0 1", a_hs, a_busy); end
        tick(4);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL s2_done got %0b exp 1", a_done); end
        checks++; if (a_pass !== 2 || a_fail !== 1 || a_nores !== 1 || a_all_pass !== 1'b0) begin errors++; $display("FAIL s2_counts got %0d/%0d/%0d all=%0b exp 2/1/1 0", a_pass, a_fail, a_nores, a_all_pass); end
        checks++; if (a_nclk !== 3) begin errors++; $display("FAIL s2_num_clock got %0d exp 3", a_nclk); end
    endtask

    task automatic test_no_stop();
        do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drive(16'h3, 16'h0);
        drive(16'h3, 16'h1);
        checks++; if (b_busy !== 1'b1 || b_ffv !== 1'b1 || b_ffi !== 0 || b_ffval !== 16'h1) begin errors++; $display("FAIL s3_capture busy=%0b v=%0b idx=%0d val=%h exp 1 1 0 0001", b_busy, b_ffv, b_ffi, b_ffval); end
        drive(16'h5, 16'h0);
        drive(16'hb, 16'h1);
        drive(16'hd, 16'h2);
        checks++; if (b_busy !== 1'b1 || b_done !== 1'b0) begin errors++; $display("FAIL s3_running busy=%0b done=%0b exp 1 0", b_busy, b_done); end
        is_halted = 1'b1;
        tick(5);
        checks++; if (b_done !== 1'b1 || b_hs !== 1'b1) begin errors++; $display("FAIL s3_done done=%0b halted=%0b exp 1 1", b_done, b_hs); end
        checks++; if (b_pass !== 3 || b_fail !== 1 || b_nores !== 0 || b_all_pass !== 1'b0) begin errors++; $display("FAIL s3_counts got %0d/%0d/%0d all=%0b exp 3/1/0 0", b_pass, b_fail, b_nores, b_all_pass); end
        checks++; if (b_nclk !== 6 || b_ffi !== 0) begin errors++; $display("FAIL s3_clock_idx got %0d/%0d exp 6/0", b_nclk, b_ffi); end
        is_halted = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        num_inst = 16'h3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(19);
        checks++; if (a_nclk !== 19 || a_busy !== 1'b1) begin errors++; $display("FAIL s4_pre got clk=%0d busy=%0b exp 19 1", a_nclk, a_busy); end
`ifdef CKMON_TIMEOUT_EN
        tick(1);
        checks++; if (a_nclk !== 20 || a_to !== 1'b1) begin errors++; $display("FAIL s4_timeout clk=%0d to=%0b exp 20 1", a_nclk, a_to); end
        tick(3);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL s4_done_early got %0b exp 0", a_done); end
        tick(1);
`else
        tick(11);
        checks++; if (a_nclk !== 30 || a_to !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL s4_notimeout clk=%0d to=%0b busy=%0b exp 30 0 1", a_nclk, a_to, a_busy); end
        is_halted = 1'b1;
        tick(5);
`endif
        checks++; if (a_done !== 1'b1 || a_pass !== 1 || a_fail !== 0 || a_nores !== 3) begin errors++; $display("FAIL s4_done done=%0b counts %0d/%0d/%0d exp 1 1/0/3", a_done, a_pass, a_fail, a_nores); end
        is_halted = 1'b0;
    endtask

    task automatic test_run_ignores();
        do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drive(16'h3, 16'h0);
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_inst = 16'h5;
        cfg_ans = 16'h7;
        start = 1'b1;
        drive(16'h5, 16'h0);
        cfg_we = 1'b0;
        start = 1'b0;
        checks++; if (a_nclk !== 2 || a_busy !== 1'b1 || a_ffv !== 1'b0) begin errors++; $display("FAIL s5_run clk=%0d busy=%0b ffv=%0b exp 2 1 0", a_nclk, a_busy, a_ffv); end
        drive(16'hb, 16'h1);
        drive(16'hd, 16'h2);
        is_halted = 1'b1;
        tick(5);
        checks++; if (a_done !== 1'b1 || a_all_pass !== 1'b1 || a_nclk !== 5) begin errors++; $display("FAIL s5_done done=%0b all=%0b clk=%0d exp 1 1 5", a_done, a_all_pass, a_nclk); end
        is_halted = 1'b0;
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_idx = 3'd1;
        cfg_inst = 16'hd;
        cfg_ans = 16'h5;
        tick(2);
        start = 1'b0;
        cfg_we = 1'b0;
        checks++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== 4 || a_nclk !== 5) begin errors++; $display("FAIL s5_frozen done=%0b busy=%0b pass=%0d clk=%0d exp 1 0 4 5", a_done, a_busy, a_pass, a_nclk); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        run_s1();
        tick(2);
        checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL s6_in_scan busy=%0b done=%0b exp 1 0", a_busy, a_done); end
        reset_n = 1'b0;
        tick(1);
        checks++; if ({a_busy, a_done, a_all_pass, a_pass, a_fail, a_nores, a_ffv, a_ffi, a_ffval, a_nclk, a_hs, a_to} !== '0) begin errors++; $display("FAIL s6_reset got %h exp 0", {a_busy, a_done, a_all_pass, a_pass, a_fail, a_nores, a_ffv, a_ffi, a_ffval, a_nclk, a_hs, a_to}); end
        reset_n = 1'b1;
        run_s1();
        tick(4);
        checks++; if (a_done !== 1'b1 || a_all_pass !== 1'b1 || a_pass !== 4) begin errors++; $display("FAIL s6_rerun done=%0b all=%0b pass=%0d exp 1 1 4", a_done, a_all_pass, a_pass); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_all_pass();
        test_first_fail();
        test_no_stop();
        test_timeout();
        test_run_ignores();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
